// File: rtl/grayscale_if.sv
// grayscale: FIFO-side bundle.
// Input FIFO pop side plus output FIFO push side.
interface grayscale_if #(
  parameter int DWIDTH_IN  = 24,
  parameter int DWIDTH_OUT = 8
);
  logic                  fifo_in_rd_en;
  logic [DWIDTH_IN-1:0]  fifo_in_dout;
  logic                  fifo_in_empty;
  logic                  fifo_out_wr_en;
  logic [DWIDTH_OUT-1:0] fifo_out_din;
  logic                  fifo_out_full;

  modport master (
    output fifo_in_rd_en,
    input  fifo_in_dout,
    input  fifo_in_empty,
    output fifo_out_wr_en,
    output fifo_out_din,
    input  fifo_out_full
  );

  modport slave (
    input  fifo_in_rd_en,
    output fifo_in_dout,
    output fifo_in_empty,
    input  fifo_out_wr_en,
    input  fifo_out_din,
    output fifo_out_full
  );
endinterface

// File: rtl/grayscale.sv
// grayscale: RGB888 to 8-bit luma, 3-stage pipe.
// Frames are drained before the next one is read.
module grayscale #(
  parameter int DWIDTH_IN  = 24,
  parameter int DWIDTH_OUT = 8,
  parameter int IMG_WIDTH  = 720,
  parameter int IMG_HEIGHT = 540
) (
  input  logic        clock,
  input  logic        reset,
  grayscale_if.master bus,
  output logic        frame_done
);

  localparam int NPIX = IMG_WIDTH * IMG_HEIGHT;
  localparam int CW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam logic [CW-1:0] LAST = CW'(NPIX - 1);

  typedef enum logic {
    RUN,
    DRAIN
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [CW-1:0] count;
  logic [CW-1:0] count_n;
  logic          done_n;

  logic          v1;
  logic          v2;
  logic          v3;
  logic [7:0]    r1;
  logic [7:0]    g1;
  logic [7:0]    b1;
  logic [15:0]   p_r;
  logic [15:0]   p_g;
  logic [15:0]   p_b;
  logic [15:0]   sum;
  logic          advance;
  logic          rd_en;
  logic          wr_en;

  // Handshake: the pipe moves unless a held result faces a full FIFO.
  assign advance = !v3 || !bus.fifo_out_full;
  assign rd_en   = reset && (state == RUN)
                && !bus.fifo_in_empty && advance;
  assign wr_en   = reset && v3 && !bus.fifo_out_full;
  assign sum     = p_r + p_g + p_b;

  assign bus.fifo_in_rd_en  = rd_en;
  assign bus.fifo_out_wr_en = wr_en;

  // Datapath: fields, weighted products, truncated sum.
  always_ff @(posedge clock) begin
    if (!reset) begin
      v1               <= 1'b0;
      v2               <= 1'b0;
      v3               <= 1'b0;
      r1               <= '0;
      g1               <= '0;
      b1               <= '0;
      p_r              <= '0;
      p_g              <= '0;
      p_b              <= '0;
      bus.fifo_out_din <= '0;
    end else if (advance) begin
      v1               <= rd_en;
      r1               <= bus.fifo_in_dout[23:16];
      g1               <= bus.fifo_in_dout[15:8];
      b1               <= bus.fifo_in_dout[7:0];
      v2               <= v1;
      p_r              <= 16'(r1) * 16'd77;
      p_g              <= 16'(g1) * 16'd150;
      p_b              <= 16'(b1) * 16'd29;
      v3               <= v2;
      bus.fifo_out_din <= DWIDTH_OUT'(sum[15:8]);
    end
  end

  // Frame control state: mode, pixel count, done pulse.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= RUN;
      count      <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      count      <= count_n;
      frame_done <= done_n;
    end
  end

  // Next state: wrap on the last read, wait for an empty pipe.
  always_comb begin
    state_n = state;
    count_n = count;
    done_n  = 1'b0;
    unique case (state)
      RUN: begin
        if (rd_en) begin
          if (count == LAST) begin
            count_n = '0;
            state_n = DRAIN;
          end else begin
            count_n = count + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (!(v1 || v2 || v3)) begin
          done_n  = 1'b1;
          state_n = RUN;
        end
      end
      default: state_n = RUN;
    endcase
  end

endmodule

// File: tb/tb_grayscale.sv
// tb_grayscale: scoreboard bench for grayscale.
// Small 4x2 frame; FIFO models live in the bench.
module tb_grayscale;

  localparam int W    = 4;
  localparam int H    = 2;
  localparam int NPIX = W * H;

  typedef struct {
    logic [7:0] g;
    bit         last;
    int         rdc;
  } exp_t;

  logic clock;
  logic reset;
  logic frame_done;

  grayscale_if #(.DWIDTH_IN(24), .DWIDTH_OUT(8)) bus ();

  grayscale #(
    .DWIDTH_IN (24),
    .DWIDTH_OUT(8),
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .frame_done(frame_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [23:0] in_q[$];
  logic [7:0]  in_exp_q[$];
  exp_t        exp_q[$];

  int n_chk;
  int n_fail;
  int cyc;
  int dones;
  int rd_in_frame;
  int last_wr;
  int wr_run;
  int max_run;
  bit draining;
  bit done_pend;
  bit rst_drv;
  bit full_ctl;
  bit hold_in;
  bit bubbles;
  bit lat_on;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] gray(logic [23:0] p);
    int s;
    s = 77 * int'(p[23:16]) + 150 * int'(p[15:8]) + 29 * int'(p[7:0]);
    return 8'(s >> 8);
  endfunction

  task automatic push_px(logic [23:0] p, logic [7:0] e);
    in_q.push_back(p);
    in_exp_q.push_back(e);
  endtask

  task automatic push_rand(int n);
    logic [23:0] p;
    for (int i = 0; i < n; i++) begin
      p = 24'($urandom);
      push_px(p, gray(p));
    end
  endtask

  task automatic step();
    bit   e_now;
    exp_t e;
    @(negedge clock);
    reset             = rst_drv;
    bus.fifo_out_full = full_ctl;
    e_now = (in_q.size() == 0) || hold_in
         || (bubbles && ($urandom_range(1, 0) == 1));
    bus.fifo_in_empty = e_now;
    bus.fifo_in_dout  = (in_q.size() != 0) ? in_q[0] : 24'h0;
    #1;
    cyc++;
    if (!rst_drv) begin
      check("rst_rd_en", 32'(bus.fifo_in_rd_en), 0);
      check("rst_wr_en", 32'(bus.fifo_out_wr_en), 0);
    end
    if (frame_done) begin
      check("done_pending", 32'(done_pend), 1);
      check("done_latency", 32'(cyc - last_wr), 2);
      done_pend = 0;
      draining  = 0;
      dones++;
    end
    if (full_ctl)
      check("wr_while_full", 32'(bus.fifo_out_wr_en), 0);
    if (bus.fifo_out_wr_en) begin
      if (exp_q.size() == 0) begin
        check("unexpected_wr", 32'(exp_q.size()), 1);
      end else begin
        e = exp_q.pop_front();
        check("gray", 32'(bus.fifo_out_din), 32'(e.g));
        if (lat_on)
          check("latency", 32'(cyc - e.rdc), 3);
        if (e.last) begin
          last_wr   = cyc;
          done_pend = 1;
        end
      end
      wr_run++;
      if (wr_run > max_run) max_run = wr_run;
    end else begin
      wr_run = 0;
    end
    if (bus.fifo_in_rd_en) begin
      check("rd_nonempty", 32'(e_now), 0);
      check("rd_in_drain", 32'(draining), 0);
      if (in_q.size() != 0) begin
        void'(in_q.pop_front());
        e.g   = in_exp_q.pop_front();
        e.rdc = cyc;
        rd_in_frame++;
        e.last = (rd_in_frame == NPIX);
        if (e.last) begin
          rd_in_frame = 0;
          draining    = 1;
        end
        exp_q.push_back(e);
      end
    end
    if (full_ctl)
      check("inflight_max", 32'(exp_q.size() > 3), 0);
    if (!rst_drv) begin
      exp_q.delete();
      rd_in_frame = 0;
      draining    = 0;
      done_pend   = 0;
    end
  endtask

  task automatic run_until_done(int n);
    int tgt;
    tgt = dones + n;
    for (int i = 0; i < 600 && dones < tgt; i++) step();
    check("done_count", 32'(dones), 32'(tgt));
    for (int i = 0; i < 4; i++) step();
    check("done_once", 32'(dones), 32'(tgt));
  endtask

  task automatic run_until_reads(int n);
    for (int i = 0; i < 200 && rd_in_frame != n; i++) step();
    check("reach_reads", 32'(rd_in_frame), 32'(n));
  endtask

  initial begin
    reset             = 1'b0;
    bus.fifo_in_empty = 1'b1;
    bus.fifo_in_dout  = '0;
    bus.fifo_out_full = 1'b0;
    rst_drv = 0;

    // reset state
    step();
    step();
    check("rst_din", 32'(bus.fifo_out_din), 0);
    check("rst_done", 32'(frame_done), 0);
    rst_drv = 1;
    step();

    // color points streamed as one frame, plus next-frame pixel
    lat_on = 1;
    push_px(24'hFFFFFF, 8'hFF);
    push_px(24'hFF0000, 8'h4C);
    push_px(24'h00FF00, 8'h95);
    push_px(24'h0000FF, 8'h1C);
    push_px(24'h808080, 8'h80);
    push_px(24'h000000, 8'h00);
    push_px(24'h123456, 8'h2D);
    push_px(24'hABCDEF, 8'hC6);
    push_rand(1);
    max_run = 0;
    run_until_done(1);
    check("stream_run", 32'(max_run), 8);
    lat_on = 0;

    // random bubbles over two frames
    bubbles = 1;
    push_rand(NPIX - 1 + NPIX);
    run_until_done(2);
    bubbles = 0;

    // back-pressure mid-stream
    push_rand(NPIX);
    run_until_reads(2);
    full_ctl = 1;
    for (int i = 0; i < 10; i++) step();
    check("held_pixels", 32'(exp_q.size()), 3);
    full_ctl = 0;
    step();
    check("resume_wr", 32'(bus.fifo_out_wr_en), 1);
    run_until_done(1);

    // release of full coincides with the last read
    push_rand(NPIX);
    run_until_reads(NPIX - 1);
    full_ctl = 1;
    hold_in  = 1;
    for (int i = 0; i < 5; i++) step();
    full_ctl = 0;
    hold_in  = 0;
    step();
    check("simul_rd", 32'(bus.fifo_in_rd_en), 1);
    check("simul_wr", 32'(bus.fifo_out_wr_en), 1);
    run_until_done(1);

    // reset after five reads
    push_rand(NPIX);
    run_until_reads(5);
    rst_drv = 0;
    step();
    rst_drv = 1;
    step();
    check("post_rst_din", 32'(bus.fifo_out_din), 0);
    check("post_rst_done", 32'(frame_done), 0);
    push_rand(5);
    run_until_done(1);

    check("sb_empty", 32'(exp_q.size()), 0);
    check("in_empty", 32'(in_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/grayscale.md
# grayscale

Pixel-conversion stage directly upstream of the Sobel edge filter. Pops 24-bit RGB pixels from the input FIFO and converts each one to 8-bit luma with a 3-stage pipelined weighted sum. Pushes the result into the FIFO that feeds the Sobel block. Counts pixels per frame and emits a one-cycle `frame_done` pulse after each frame's last gray pixel has been written, so downstream frame boundaries stay aligned.

## Interface
Parameters:
- DWIDTH_IN, 24, input pixel width; R = [23:16], G = [15:8], B = [7:0]
- DWIDTH_OUT, 8, output gray width
- IMG_WIDTH, 720, pixels per line
- IMG_HEIGHT, 540, lines per frame

Ports:
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-low (0 = reset)
- fifo_in_rd_en  out  1  pop request to input FIFO (FWFT: dout valid while !empty)
- fifo_in_dout  in  DWIDTH_IN  RGB pixel at head of input FIFO
- fifo_in_empty  in  1  input FIFO empty
- fifo_out_wr_en  out  1  push to output FIFO
- fifo_out_din  out  DWIDTH_OUT  gray pixel, valid when fifo_out_wr_en=1
- fifo_out_full  in  1  output FIFO full
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is written

## Operation
- Conversion: gray = (77·R + 150·G + 29·B) >> 8, truncated.
  - Products are 16 bits; the sum fits in 16 bits (max 65280); output is sum[15:8]. No rounding, no saturation needed.
- Pipeline, each stage with a valid bit v1/v2/v3:
  - S1 registers the RGB fields.
  - S2 registers the three products.
  - S3 registers the sum[15:8] into `fifo_out_din`.
- advance = !v3 | !fifo_out_full. When advance=1 all stages shift and v1 loads fifo_in_rd_en. When advance=0 all stage registers and valids hold.
- fifo_out_wr_en = v3 & !fifo_out_full (combinational). This guarantees no write to a full FIFO.
- fifo_in_rd_en = (state==RUN) & !fifo_in_empty & advance (combinational). This guarantees no read from an empty FIFO.
- Pixel counter: width $clog2(IMG_WIDTH·IMG_HEIGHT). Increments on every fifo_in_rd_en.
- State machine:
  - RUN: read as above. On a read with count == IMG_WIDTH·IMG_HEIGHT−1, set count to 0 and go to DRAIN.
  - DRAIN: no reads; the pipeline continues to advance and write. When v1=v2=v3=0, set frame_done register to 1 and go to RUN.
  - frame_done is 1 for exactly one cycle, then returns to 0.
- Next frame: pixels of the next frame waiting in the input FIFO are not consumed until the pipeline has drained. A frame's outputs never interleave with the next frame's.
- Reset (reset=0 at a clock edge), including mid-frame or mid-drain:
  - Resets state to RUN, count, v1..v3, fifo_out_din and frame_done to 0.
  - Pipeline contents are discarded.
  - While reset=0, fifo_in_rd_en=0 and fifo_out_wr_en=0, forced combinationally.

## Timing
- Latency: a pixel popped in cycle N appears with fifo_out_wr_en=1 in cycle N+3 when fifo_out_full=0.
- Throughput: 1 pixel/cycle sustained with non-empty input and non-full output.
- Back-pressure: with fifo_out_full=1 and v3=1, rd_en drops in the same cycle. Up to 3 pixels are held in the pipeline, none lost. Writes resume in the first cycle full deasserts.
- Bubbles: an empty input creates a gap; valid bits carry the gap, and no write occurs for bubble slots.
- End of frame: last write in cycle T, DRAIN sees an empty pipeline in cycle T+1, frame_done=1 in cycle T+2. The earliest next-frame read is in cycle T+2.
- Reset outputs: fifo_in_rd_en=0, fifo_out_wr_en=0, fifo_out_din=0x00, frame_done=0.

## Test plan
- Color points, with IMG_WIDTH=4 and IMG_HEIGHT=2: inputs 0xFFFFFF, 0xFF0000, 0x00FF00, 0x0000FF, 0x808080, 0x000000 must produce 0xFF, 0x4C, 0x95, 0x1C, 0x80, 0x00 in order. Each write lands 3 cycles after its read.
- Full streaming: feed 8 pixels back-to-back, output never full.
  - Required: 8 consecutive write cycles.
  - frame_done high exactly once, 2 cycles after the 8th write.
  - A 9th queued pixel is not read before that pulse.
- Back-pressure: hold fifo_out_full=1 for 10 cycles mid-stream.
  - Required: rd_en goes low once v3 fills, with at most 3 pixels in flight.
  - Zero writes while full.
  - After release, the output sequence is identical to the unstalled reference.
- Bubbles: toggle fifo_in_empty randomly (50%) over 2 frames. Required: output equals input pixel order converted, with exactly 2 frame_done pulses.
- Reset: assert reset=0 for 1 cycle after 5 pixels of a frame have been read.
  - Required: all outputs 0 during reset; no write of the discarded in-flight pixels.
  - Counter restarts, so frame_done fires only after 8 further pixels.
- Simultaneous events: fifo_out_full deasserts in the same cycle the last frame pixel is read. Required: count wraps to 0, DRAIN entered, and frame_done pulses exactly once after the final write.
